pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; generalises the single-stage MEM control latch.
- Carries a control field (e.g. mem_write/mem_read/branch) and a data field through DEPTH register stages, with a per-stage valid bit.
- Supports stall (hold) and flush (bubble insertion).
- Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); the hazard unit drives stall and flush.

Parameters:
- CTRL_W, 3, width of control field; zeroed on bubbles, legal range >=1.
- DATA_W, 32, width of data field; never zeroed by flush, legal range >=1.
- DEPTH, 1, number of register stages; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- stall_i  input  1  hold all stages this cycle.
- flush_i  input  1  invalidate all stages this cycle.
- valid_i  input  1  incoming instruction valid.
- ctrl_i  input  CTRL_W  incoming control field.
- data_i  input  DATA_W  incoming data field.
- valid_o  output  1  valid bit of stage DEPTH-1.
- ctrl_o  output  CTRL_W  control field of stage DEPTH-1.
- data_o  output  DATA_W  data field of stage DEPTH-1.
- occ_o  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset: reset is synchronous and active-low. At a posedge with rst==0, all stage valid, ctrl and data registers clear to 0.
  - Therefore valid_o=0, ctrl_o=0, data_o=0 and occ_o=0 one cycle after reset is sampled.
  - Reset overrides stall_i and flush_i.
- Stages are indexed 0..DEPTH-1. Stage 0 loads from the inputs. Outputs are driven directly from stage DEPTH-1 registers with no combinational path from the inputs.
- Per-posedge priority, with rst==1: flush > stall > advance.
- Flush (flush_i==1):
  - Every stage gets valid<=0 and ctrl<=0.
  - Data registers hold their value.
  - valid_i, ctrl_i and data_i are discarded this cycle.
- Stall (stall_i==1, flush_i==0):
  - All stages hold valid, ctrl and data.
  - Inputs are discarded; upstream must hold them.
- Advance (both low):
  - Stage k loads stage k-1 for k>=1.
  - Stage 0 loads valid<=valid_i, ctrl<=(valid_i ? ctrl_i : 0), data<=data_i.
  - An invalid input therefore never produces non-zero control at the output.
- Latency: exactly DEPTH non-stalled, non-flushed cycles from input to output.
- DEPTH=1 is cycle-equivalent to a single latch with added stall, flush and valid.
- Stall and flush affect the whole chain; there is no per-stage stall.
- Control invariant: for any stage, valid==0 implies ctrl==0, at all times after reset.
- occ_o: combinational popcount of the stage valid bits.
  - Range 0..DEPTH, with no overflow by construction.
  - Updates in the same cycle the valid bits change.
- Simultaneous stall_i and flush_i: flush wins.
- Reset asserted mid-stall or mid-flush: reset wins.
- Pipeline full with stall: contents retained indefinitely. There is no overflow condition; upstream stalls in lockstep.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: adds two outputs, each 16 bits wide:
  - stall_cnt_o increments on each posedge with rst==1, stall_i==1 and flush_i==0.
  - flush_cnt_o increments on each posedge with rst==1 and flush_i==1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counter logic are absent; the remaining behaviour is identical.

Test Plan:
1. DEPTH=3, reset low for 2 cycles then release.
   - Stimulus: feed valid_i=1 with ctrl_i=3'b101/data_i=0x11, then 3'b010/0x22, then 3'b001/0x33.
   - Response: outputs show 0x11, 0x22, 0x33 on cycles 3, 4, 5 after the first load, with matching ctrl and valid_o=1.
   - Response: occ_o steps 1, 2, 3.
2. DEPTH=3, pipeline full (0x11, 0x22, 0x33), stall_i=1 for 4 cycles.
   - Response: outputs frozen at 0x11/3'b101 and occ_o=3 throughout.
   - Response: after release, 0x22 emerges on the next cycle.
3. DEPTH=3, full pipeline, flush_i=1 for 1 cycle.
   - Response: next cycle valid_o=0, ctrl_o=0, occ_o=0, data_o still 0x11.
   - Response: a new input loaded after the flush appears 3 cycles later.
4. Stimulus: stall_i=1 and flush_i=1 together on a full pipeline.
   - Response: identical to the flush-only case; all valid=0.
5. Stimulus: valid_i=0 with ctrl_i=3'b111, data_i=0xAA.
   - Response: emerges DEPTH cycles later with valid_o=0, ctrl_o=0, data_o=0xAA.
6. Stimulus: rst=0 asserted during a stall with occ_o=2.
   - Response: next cycle all outputs 0.
   - With PIPE_STAGE_STATS_EN defined: counters are 0 after reset, and 70000 stall cycles give stall_cnt_o=0xFFFF (saturated).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
//
// Carries a control field and a data field through DEPTH register stages,
// each with its own valid bit. The hazard unit drives stall_i (hold the whole
// chain) and flush_i (turn every stage into a bubble). Bubbles always carry
// zero control so downstream stages never act on a dead instruction; the
// data field is left alone on a flush because nothing consumes it while the
// stage is invalid.
//
// Optional build macro: PIPE_STAGE_STATS_EN
//   When defined, adds 16-bit saturating stall_cnt_o / flush_cnt_o outputs.
//   When undefined, those ports and their counters do not exist.
//
// Reset is synchronous and active-low (rst), sampled on the rising edge.

module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [OCC_W-1:0]  occ_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  // What the chain does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    OP_RESET,
    OP_FLUSH,
    OP_HOLD,
    OP_ADVANCE
  } stage_op_e;

  stage_op_e op;

  // Per-stage state. Index 0 is fed from the inputs, DEPTH-1 drives outputs.
  logic [DEPTH-1:0]  valid_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Control presented to stage 0: an invalid input is forced to a bubble.
  logic [CTRL_W-1:0] ctrl_in_masked;

  // Decode the per-edge operation: reset > flush > stall > advance.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    op = OP_ADVANCE;
    if (!rst) begin
      op = OP_RESET;
    end else if (flush_i) begin
      op = OP_FLUSH;
    end else if (stall_i) begin
      op = OP_HOLD;
    end
  end

  // Mask the incoming control so an invalid instruction carries no control.
  always_comb begin
    ctrl_in_masked = valid_i ? ctrl_i : '0;
  end

  // Valid and control chain: cleared on reset and flush, shifted on advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift order is irrelevant.
    unique case (op)
      OP_RESET, OP_FLUSH: begin
        valid_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          ctrl_q[k] <= '0;
        end
      end
      OP_HOLD: begin
        valid_q <= valid_q;
      end
      OP_ADVANCE: begin
        valid_q[0] <= valid_i;
        ctrl_q[0]  <= ctrl_in_masked;
        for (int k = 1; k < DEPTH; k++) begin
          valid_q[k] <= valid_q[k-1];
          ctrl_q[k]  <= ctrl_q[k-1];
        end
      end
      default: begin
        valid_q <= valid_q;
      end
    endcase
  end

  // Data chain: cleared on reset, untouched by flush, shifted on advance.
  always_ff @(posedge clk) begin
    // NOTE: the data registers are reset even though flush leaves them alone,
    // because data_o must read zero after reset; they are flops, not a RAM.
    unique case (op)
      OP_RESET: begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
        end
      end
      OP_ADVANCE: begin
        data_q[0] <= data_i;
        for (int k = 1; k < DEPTH; k++) begin
          data_q[k] <= data_q[k-1];
        end
      end
      default: begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= data_q[k];
        end
      end
    endcase
  end

  // Outputs come straight from the last stage; no path from the inputs.
  always_comb begin
    valid_o = valid_q[DEPTH-1];
    ctrl_o  = ctrl_q[DEPTH-1];
    data_o  = data_q[DEPTH-1];
  end

  // Occupancy: popcount of the stage valid bits, bounded by DEPTH.
  always_comb begin
    occ_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_o = occ_o + OCC_W'(valid_q[k]);
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating count of edges spent holding (stall without flush).
  always_ff @(posedge clk) begin
    if (op == OP_RESET) begin
      stall_cnt_q <= '0;
    end else if (op == OP_HOLD && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Saturating count of edges spent flushing.
  always_ff @(posedge clk) begin
    if (op == OP_RESET) begin
      flush_cnt_q <= '0;
    end else if (op == OP_FLUSH && flush_cnt_q != 16'hFFFF) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  // Expose the statistics counters.
  always_comb begin
    stall_cnt_o = stall_cnt_q;
    flush_cnt_o = flush_cnt_q;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg at DEPTH=3.
// The reference model is a fixed-length queue of instruction records: an
// advance pushes the new record at the front and drops the oldest, a flush
// kills every record (keeping its data), a stall changes nothing.

module tb_pipe_stage_reg;

  localparam int CTRL_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [OCC_W-1:0]  occ_o;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]       stall_cnt_o;
  logic [15:0]       flush_cnt_o;
`endif

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ctrl_o  (ctrl_o),
    .data_o  (data_o),
    .occ_o   (occ_o)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              v;
    bit [CTRL_W-1:0] c;
    bit [DATA_W-1:0] d;
  } rec_t;

  rec_t mdl[$];
  int   exp_stall_cnt;
  int   exp_flush_cnt;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (mdl[i]) n += int'(mdl[i].v);
    return n;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit f,
                            input bit v, input bit [CTRL_W-1:0] c, input bit [DATA_W-1:0] d);
    rec_t e;
    if (!r) begin
      mdl.delete();
      for (int i = 0; i < DEPTH; i++) begin
        e.v = 0; e.c = '0; e.d = '0;
        mdl.push_back(e);
      end
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else if (f) begin
      foreach (mdl[i]) begin
        mdl[i].v = 0;
        mdl[i].c = '0;
      end
      if (exp_flush_cnt < 65535) exp_flush_cnt++;
    end else if (s) begin
      if (exp_stall_cnt < 65535) exp_stall_cnt++;
    end else begin
      e.v = v;
      e.c = v ? c : '0;
      e.d = d;
      mdl.push_front(e);
      void'(mdl.pop_back());
    end
  endtask

  task automatic check_outputs(input string tag);
    rec_t o;
    o = mdl[DEPTH-1];
    check({tag, ".valid"}, 32'(valid_o), 32'(o.v));
    check({tag, ".ctrl"},  32'(ctrl_o),  32'(o.c));
    check({tag, ".data"},  data_o,       o.d);
    check({tag, ".occ"},   32'(occ_o),   32'(model_occ()));
`ifdef PIPE_STAGE_STATS_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(exp_stall_cnt));
    check({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(exp_flush_cnt));
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model, then compare.
  task automatic step(input string tag, input bit r, input bit s, input bit f,
                      input bit v, input bit [CTRL_W-1:0] c, input bit [DATA_W-1:0] d);
    rst = r; stall_i = s; flush_i = f; valid_i = v; ctrl_i = c; data_i = d;
    @(posedge clk);
    model_edge(r, s, f, v, c, d);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    #2;

    // Reset for two cycles, then known-zero outputs.
    step("reset0", 0, 0, 0, 1, 3'b111, 32'hDEAD);
    step("reset1", 0, 1, 1, 1, 3'b111, 32'hBEEF);
    check("reset.occ_zero", 32'(occ_o), 32'd0);

    // Fill: occupancy steps 1, 2, 3, first record reaches the output.
    step("fill0", 1, 0, 0, 1, 3'b101, 32'h11);
    check("fill0.occ1", 32'(occ_o), 32'd1);
    step("fill1", 1, 0, 0, 1, 3'b010, 32'h22);
    check("fill1.occ2", 32'(occ_o), 32'd2);
    step("fill2", 1, 0, 0, 1, 3'b001, 32'h33);
    check("fill2.data11", data_o, 32'h11);
    check("fill2.ctrl101", 32'(ctrl_o), 32'd5);
    check("fill2.occ3", 32'(occ_o), 32'd3);

    // Stall four cycles on a full pipe: frozen, inputs discarded.
    for (int i = 0; i < 4; i++) begin
      step("stall", 1, 1, 0, 1, 3'(i), 32'hF0 + 32'(i));
      check("stall.data11", data_o, 32'h11);
    end
    step("release", 1, 0, 0, 1, 3'b100, 32'h44);
    check("release.data22", data_o, 32'h22);
    check("release.ctrl010", 32'(ctrl_o), 32'd2);

    // Flush: everything invalid, control zero, data held.
    step("flush", 1, 0, 1, 1, 3'b111, 32'hEE);
    check("flush.occ0", 32'(occ_o), 32'd0);
    check("flush.data_held", data_o, 32'h22);

    // A record loaded after the flush appears three cycles later.
    step("post0", 1, 0, 0, 1, 3'b110, 32'h55);
    step("post1", 1, 0, 0, 0, 3'b000, 32'h0);
    step("post2", 1, 0, 0, 0, 3'b000, 32'h0);
    check("post.data55", data_o, 32'h55);
    check("post.valid", 32'(valid_o), 32'd1);

    // Refill, then stall and flush together: flush wins.
    step("refill0", 1, 0, 0, 1, 3'b011, 32'h66);
    step("refill1", 1, 0, 0, 1, 3'b101, 32'h77);
    step("refill2", 1, 0, 0, 1, 3'b111, 32'h88);
    step("stallflush", 1, 1, 1, 1, 3'b111, 32'h99);
    check("stallflush.occ0", 32'(occ_o), 32'd0);
    check("stallflush.valid0", 32'(valid_o), 32'd0);

    // Invalid input with non-zero control emerges as a bubble carrying data.
    step("inv0", 1, 0, 0, 0, 3'b111, 32'hAA);
    step("inv1", 1, 0, 0, 0, 3'b000, 32'h1);
    step("inv2", 1, 0, 0, 0, 3'b000, 32'h2);
    check("inv.dataAA", data_o, 32'hAA);
    check("inv.ctrl0", 32'(ctrl_o), 32'd0);

    // Reset during a stall with two valid stages.
    step("two0", 1, 0, 0, 1, 3'b001, 32'hB1);
    step("two1", 1, 0, 0, 1, 3'b010, 32'hB2);
    step("two_stall", 1, 1, 0, 1, 3'b011, 32'hB3);
    check("two_stall.occ2", 32'(occ_o), 32'd2);
    step("rst_in_stall", 0, 1, 0, 1, 3'b111, 32'hB4);
    check("rst_in_stall.data0", data_o, 32'h0);
    check("rst_in_stall.occ0", 32'(occ_o), 32'd0);

    // Randomised traffic with occasional reset, stall and flush.
    for (int i = 0; i < 400; i++) begin
      bit r, s, f, v;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      step("rand", r, s, f, v, 3'($urandom), $urandom);
    end

`ifdef PIPE_STAGE_STATS_EN
    // Counters clear on reset and saturate after a long stall.
    step("stats_rst", 0, 0, 0, 0, 3'b000, 32'h0);
    check("stats_rst.stall0", 32'(stall_cnt_o), 32'd0);
    check("stats_rst.flush0", 32'(flush_cnt_o), 32'd0);
    rst = 1; stall_i = 1; flush_i = 0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_edge(1, 1, 0, 0, '0, '0);
    end
    #1;
    check("stats_sat.stall", 32'(stall_cnt_o), 32'hFFFF);
    check_outputs("stats_sat");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
